// File: rtl/key_gate_lab_if.sv
// rtl/key_gate_lab_if.sv - board pin bundle: push-buttons, switches and LEDs
interface key_gate_lab_if #(
  parameter int W = 4
);
  logic [1:0]     key;
  logic [2*W-1:0] sw;
  logic [W+5:0]   led;

  // board side drives the pins and watches the LEDs
  modport master (output key, output sw, input led);
  // design side reads the pins and drives the LEDs
  modport slave (input key, input sw, output led);
endinterface

// File: rtl/key_gate_lab.sv
// rtl/key_gate_lab.sv - W-bit bitwise function explorer with debounced mode/hold keys
module key_gate_lab #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input logic         clk,
  input logic         reset,
  key_gate_lab_if.slave io
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]     key_sync [SYNC_STAGES];
  logic [2*W-1:0] sw_sync  [SYNC_STAGES];
  logic [CW-1:0]  cnt      [2];
  logic [1:0]     stable;
  logic [1:0]     stable_d;
  logic [1:0]     pulse;
  logic [2:0]     mode;
  logic           hold;
  logic [W+5:0]   led_q;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     key_lvl;
  logic [W-1:0]   res;

  assign key_lvl = key_sync[SYNC_STAGES-1];
  assign a       = sw_sync[SYNC_STAGES-1][W-1:0];
  assign b       = sw_sync[SYNC_STAGES-1][2*W-1:W];
  assign io.led  = led_q;

  // synchronise the asynchronous pins; keys idle released (1), switches idle 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        key_sync[i] <= 2'b11;
        sw_sync[i]  <= '0;
      end
    end else begin
      key_sync[0] <= io.key;
      sw_sync[0]  <= io.sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        key_sync[i] <= key_sync[i-1];
        sw_sync[i]  <= sw_sync[i-1];
      end
    end
  end

  // per-key debounce; press pulse fires the cycle after stable falls 1->0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) cnt[k] <= '0;
      stable   <= 2'b11;
      stable_d <= 2'b11;
      pulse    <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (key_lvl[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          stable[k] <= ~stable[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
      stable_d <= stable;
      pulse    <= stable_d & ~stable;
    end
  end

  // selected bitwise function of the synchronised operands
  always_comb begin
    res = '0;
    case (mode)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = ~a;
      3'd3:    res = a ^ b;
      3'd4:    res = ~(a & b);
      3'd5:    res = ~(a | b);
      3'd6:    res = ~(a ^ b);
      default: res = a + b;
    endcase
  end

  // mode steps on key[0] unless frozen; hold toggles on key[1]; LEDs register every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode  <= 3'd0;
      hold  <= 1'b0;
      led_q <= '0;
    end else begin
      if (pulse[0] && !hold) mode <= mode + 3'd1;
      if (pulse[1])          hold <= ~hold;
      led_q[W+2:W] <= mode;
      led_q[W+3]   <= hold;
      if (!hold) begin
        led_q[W-1:0] <= res;
        led_q[W+4]   <= ^res;
        led_q[W+5]   <= (a == b);
      end
    end
  end
endmodule

// File: tb/tb_key_gate_lab.sv
// tb/tb_key_gate_lab.sv - scoreboard bench for key_gate_lab with directed vectors
module tb_key_gate_lab;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  key_gate_lab_if #(.W(4)) bus ();

  key_gate_lab #(
    .W(4),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  logic [9:0] exp_q [$];
  string      name_q [$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] mon_e;
  string      mon_n;

  task automatic expect_led(input string nm, input logic [9:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    bus.key[k] = 1'b0;
    tick(10);
    bus.key[k] = 1'b1;
    tick(10);
  endtask

  // monitor: compare led against every queued expectation, away from the active edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (bus.led !== mon_e) begin
        errors++;
        $display("FAIL %s: led=%h expected %h", mon_n, bus.led, mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // led map (W=4): [9]=eq [8]=parity [7]=hold [6:4]=mode [3:0]=result
  initial begin
    reset   = 1'b1;
    bus.key = 2'b00;
    bus.sw  = 8'hFF;
    tick(1);
    expect_led("reset_led_a", 10'h000);
    tick(2);
    expect_led("reset_led_b", 10'h000);
    bus.key = 2'b11;
    tick(1);
    expect_led("reset_led_c", 10'h000);
    reset = 1'b0;
    tick(3);
    expect_led("post_reset_and", 10'h20F);

    bus.sw = 8'hAC;
    tick(5);
    expect_led("mode0_and", 10'h108);
    press(0);
    expect_led("mode1_or", 10'h11E);
    press(0);
    expect_led("mode2_not", 10'h023);
    press(0);
    expect_led("mode3_xor", 10'h036);

    bus.key[0] = 1'b0; tick(3);
    bus.key[0] = 1'b1; tick(1);
    bus.key[0] = 1'b0; tick(3);
    bus.key[0] = 1'b1; tick(10);
    expect_led("glitch_ignored", 10'h036);
    bus.key[0] = 1'b0; tick(6);
    bus.key[0] = 1'b1; tick(12);
    expect_led("held6_one_advance", 10'h147);

    bus.sw = 8'h2F;
    press(0);
    expect_led("mode5_nor", 10'h050);
    press(0);
    expect_led("mode6_xnor", 10'h162);
    press(0);
    expect_led("mode7_add", 10'h171);
    press(0);
    expect_led("mode_wrap_and", 10'h102);

    press(1);
    expect_led("hold_on", 10'h182);
    bus.sw = 8'h55;
    press(0);
    press(0);
    expect_led("frozen", 10'h182);
    press(1);
    expect_led("unfreeze", 10'h205);

    press(0);
    press(0);
    expect_led("mode2_eq_operands", 10'h22A);
    bus.key = 2'b00;
    tick(10);
    bus.key = 2'b11;
    tick(10);
    expect_led("both_keys", 10'h2BA);

    bus.key[0] = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    expect_led("reset_mid_debounce", 10'h000);
    bus.key = 2'b11;
    tick(2);
    reset = 1'b0;
    tick(15);
    expect_led("no_advance_after_reset", 10'h205);

    tick(2);
    if (checks != 21) begin
      errors++;
      $display("FAIL check_count: %0d checks run, expected 21", checks);
    end
    if (errors == 0) $display("PASS");
    else             $display("FAIL: %0d errors", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_gate_lab.md
Name: key_gate_lab

Overview:
- Bench-board logic-function explorer for the DE10-Lite, generalised from fixed 1-bit gates to W-bit operands.
- Switches supply two W-bit operands.
- Debounced push-buttons step through eight bitwise functions and freeze or unfreeze the display.
- Sits directly between the board pins (key, sw) and the LEDs.
- All outputs are registered.

Parameters:
W, 4, operand width in bits; 1..8
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised key level must differ from its stable state before the stable state flips; must be >= 2
SYNC_STAGES, 2, synchroniser flops per asynchronous input; must be >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key  input  2  push-buttons, active-low (0 = pressed); key[0] = next mode, key[1] = hold toggle
sw  input  2*W  operands: a = sw[W-1:0], b = sw[2*W-1:W]
led  output  W+6  result and status (field map under Behaviour)

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - key synchronisers and debounced stable states = 1 (released);
  - sw synchronisers = 0;
  - debounce counters = 0;
  - mode = 0; hold = 0;
  - led = all zeros.
- Reset asserted mid-debounce clears the counter; no press pulse is produced for that press.
- Input synchronisation: key and sw each pass through SYNC_STAGES flops. sw has no debounce.
- Debounce (one instance per key):
  - Counter increments each cycle the synced level differs from the stable state.
  - Counter clears on any cycle the synced level equals the stable state.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the stable state flips on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Press pulse: 1 cycle long, asserted in the cycle after the stable state goes 1->0. Release produces no pulse.
- Mode register (3 bits), advanced by the key[0] pulse:
  - advances only if hold = 0;
  - increments modulo 8 (7 wraps to 0).
- Mode functions:
  - 0: a&b
  - 1: a|b
  - 2: ~a
  - 3: a^b
  - 4: ~(a&b)
  - 5: ~(a|b)
  - 6: ~(a^b)
  - 7: (a+b) mod 2^W, carry discarded
- Hold register (1 bit): toggles on each key[1] pulse.
- Simultaneous key[0] and key[1] pulses in one cycle:
  - hold = 0: mode advances and hold becomes 1 on the same edge.
  - hold = 1: mode unchanged and hold becomes 0.
- LED register: updated every edge.
  - led[W-1:0] = f(mode, a, b); loads only when hold = 0, else retains its value.
  - led[W+2:W] = mode; always loads.
  - led[W+3] = hold; always loads.
  - led[W+4] = XOR-reduction (parity) of the next led[W-1:0] value; loads only when hold = 0.
  - led[W+5] = (a == b); loads only when hold = 0.
- Because the result loads from the pre-edge mode, a freeze shows the function of the mode in force before the freezing edge.
- Latency:
  - sw change at pins to led: SYNC_STAGES+1 cycles (hold = 0).
  - Clean key press to pulse: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
  - Pulse to led mode field and result in new mode: 2 cycles.
- No combinational path from any input to led.

Test Plan:
- W=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted.
- Reset asserted with keys pressed and sw=8'hFF -> led=0 throughout reset; 3 cycles after release led[3:0]=4'hF (AND), led[9]=1, led[8]=0, led[6:4]=0.
- sw a=4'b1100, b=4'b1010; pulse key[0] low cleanly 3 times -> mode field steps 1,2,3; results 4'b1110, 4'b0011, 4'b0110.
- key[0] low for 3 cycles, high, low again for 3 -> no mode change; then held low 6 cycles -> exactly one advance.
- Advance mode to 7 with a=4'hF, b=4'h2 -> led[3:0]=4'h1, led[8]=1; one more press -> mode 0, led[3:0]=4'h2.
- Press key[1] -> led[7]=1; change sw to a=b=4'h5 and press key[0] twice -> led[3:0], led[8], led[9] and mode field frozen; press key[1] -> unfreezes with new AND result 4'h5, led[9]=1.
- Both keys released-to-pressed on the same cycle from hold=0, mode 2 -> mode 3, hold=1, led[3:0] frozen at mode-2 result; assert reset mid-debounce of key[0] -> no advance after reset release.
